// File: rtl/hatch_pkg.sv
// rtl/hatch_pkg.sv - shared types and constants for the hatch fetch stage
package hatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int INSN_W     = 48;
  localparam int INSN_BYTES = 6;
  localparam int MEM_DW     = 16;

  // An odd start straddles one extra halfword.
  function automatic logic [2:0] read_count(input logic addr_lsb);
    return addr_lsb ? 3'd4 : 3'd3;
  endfunction

endpackage

// File: rtl/hatch_fetch_buf.sv
// rtl/hatch_fetch_buf.sv - one-entry last-instruction buffer
module hatch_fetch_buf
  import hatch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inval,
  input  logic              load,
  input  logic [31:0]       load_addr,
  input  logic [INSN_W-1:0] load_insn,
  input  logic [31:0]       look_addr,
  output logic              hit,
  output logic [INSN_W-1:0] data
);

  logic              valid_q;
  logic [31:0]       tag_q;
  logic [INSN_W-1:0] data_q;

  assign hit  = valid_q && (tag_q == look_addr);
  assign data = data_q;

  // Invalidate wins over load so a flush never leaves a half-fetched entry.
  always_ff @(posedge clk) begin
    if (rst || inval) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      tag_q   <= load_addr;
      data_q  <= load_insn;
    end
  end

endmodule

// File: rtl/hatch_fetch.sv
// rtl/hatch_fetch.sv - byte-addressed 48-bit instruction fetch over 16-bit RAM
module hatch_fetch
  import hatch_pkg::*;
#(
  parameter int MEM_AW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  input  logic              fetch_flush,
  output logic              fetch_ready,
  output logic              insn_valid,
  output logic [INSN_W-1:0] insn,
  output logic              insn_err,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_rdata
);

  // Highest legal byte address; compared in 33 bits so addr+5 cannot wrap.
  localparam logic [32:0] ADDR_MAX = (33'd1 << (MEM_AW + 1)) - 33'd1;

  state_t              state_q, state_d;
  logic                accept, range_err, buf_hit, miss_go, issue, buf_load;
  logic [INSN_W-1:0]   buf_data, asm_insn;
  logic [31:0]         addr_q;
  logic                odd_q;
  logic [2:0]          cnt_q;
  logic                rd_q;
  logic [39:0]         asm_q;
  logic                mem_rd_d;
  logic [MEM_AW-1:0]   mem_addr_d;

  assign fetch_ready = (state_q == IDLE) && !rst;
  assign accept      = fetch_req && fetch_ready && !fetch_flush;
  assign range_err   = ({1'b0, fetch_addr} + 33'(INSN_BYTES - 1)) > ADDR_MAX;
  assign miss_go     = accept && !range_err && !buf_hit;
  assign issue       = (state_q == READ) && (cnt_q != read_count(odd_q));
  assign buf_load    = (state_q == DRAIN) && !fetch_flush;

  // Final halfword arrives during DRAIN; odd starts drop the leading and trailing byte.
  assign asm_insn = odd_q ? {asm_q[39:0], mem_rdata[15:8]}
                          : {asm_q[31:0], mem_rdata};

  hatch_fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .inval     (fetch_flush),
    .load      (buf_load),
    .load_addr (addr_q),
    .load_insn (asm_insn),
    .look_addr (fetch_addr),
    .hit       (buf_hit),
    .data      (buf_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and next values of the registered RAM strobe/address.
  always_comb begin
    state_d    = state_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr;
    case (state_q)
      IDLE: begin
        if (accept) state_d = miss_go ? READ : RESP;
        if (miss_go) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = fetch_addr[MEM_AW:1];
        end
      end
      READ: begin
        if (issue) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = mem_addr + 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fetch_flush) begin
      state_d    = IDLE;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr;
    end
  end

  // Datapath: request latch, read counter, halfword assembly and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      odd_q      <= 1'b0;
      cnt_q      <= '0;
      asm_q      <= '0;
      insn_valid <= 1'b0;
      insn       <= '0;
      insn_err   <= 1'b0;
    end else begin
      mem_rd     <= mem_rd_d;
      mem_addr   <= mem_addr_d;
      rd_q       <= mem_rd && !fetch_flush;
      insn_valid <= 1'b0;
      if (accept) begin
        addr_q <= fetch_addr;
        odd_q  <= fetch_addr[0];
        cnt_q  <= 3'd1;
        if (range_err) begin
          insn_valid <= 1'b1;
          insn_err   <= 1'b1;
          insn       <= '0;
        end else if (buf_hit) begin
          insn_valid <= 1'b1;
          insn_err   <= 1'b0;
          insn       <= buf_data;
        end
      end
      if (issue && !fetch_flush) cnt_q <= cnt_q + 3'd1;
      if (rd_q) asm_q <= {asm_q[23:0], mem_rdata};
      if (buf_load) begin
        insn_valid <= 1'b1;
        insn_err   <= 1'b0;
        insn       <= asm_insn;
      end
    end
  end

endmodule

// File: tb/tb_hatch_fetch.sv
// tb/tb_hatch_fetch.sv - directed self-checking bench for hatch_fetch
module tb_hatch_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_flush;
  logic        fetch_ready;
  logic        insn_valid;
  logic [47:0] insn;
  logic        insn_err;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;

  logic [15:0] ram [0:65535];

  int n_vec = 0;
  int n_err = 0;

  hatch_fetch #(.MEM_AW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_flush (fetch_flush),
    .fetch_ready (fetch_ready),
    .insn_valid  (insn_valid),
    .insn        (insn),
    .insn_err    (insn_err),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous program RAM model: data the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues one request and checks every cycle up to the response.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [47:0] ei,
                       input logic ee, input int nrd, input int lat, input logic [15:0] h0);
    int w;
    w = 0;
    fetch_req  = 1'b1;
    fetch_addr = a;
    while (!fetch_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("%s.ready", tag), 64'(fetch_ready), 64'd1);
    @(posedge clk);
    #1 fetch_req = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk($sformatf("%s.rd%0d", tag, c), 64'(mem_rd), 64'(c <= nrd));
      if (mem_rd) chk($sformatf("%s.addr%0d", tag, c), 64'(mem_addr), 64'(h0) + 64'(c - 1));
      chk($sformatf("%s.vld%0d", tag, c), 64'(insn_valid), 64'(c == lat));
    end
    chk($sformatf("%s.insn", tag), 64'(insn), 64'(ei));
    chk($sformatf("%s.err", tag), 64'(insn_err), 64'(ee));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
    ram[0] = 16'h5C01; ram[1] = 16'h0000; ram[2] = 16'h1001;
    ram[3] = 16'hAA11; ram[4] = 16'h2233; ram[5] = 16'h4455; ram[6] = 16'h66BB;
    ram[16'hFFFD] = 16'h0102; ram[16'hFFFE] = 16'h0304; ram[16'hFFFF] = 16'h0506;
    mem_rdata   = 16'h0;
    rst         = 1'b1;
    fetch_req   = 1'b0;
    fetch_addr  = 32'h0;
    fetch_flush = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst.ready", 64'(fetch_ready), 64'd0);
    chk("rst.valid", 64'(insn_valid), 64'd0);
    chk("rst.insn", 64'(insn), 64'd0);
    chk("rst.err", 64'(insn_err), 64'd0);
    chk("rst.rd", 64'(mem_rd), 64'd0);
    chk("rst.addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready_after", 64'(fetch_ready), 64'd1);

    fetch("even_miss", 32'h0, 48'h5C0100001001, 1'b0, 3, 5, 16'h0000);
    fetch("odd_miss", 32'h7, 48'h112233445566, 1'b0, 4, 6, 16'h0003);
    fetch("hit", 32'h7, 48'h112233445566, 1'b0, 0, 1, 16'h0000);
    fetch("evict", 32'h0, 48'h5C0100001001, 1'b0, 3, 5, 16'h0000);
    fetch("top_ok", 32'h1FFFA, 48'h010203040506, 1'b0, 3, 5, 16'hFFFD);
    fetch("err_1fffb", 32'h1FFFB, 48'h0, 1'b1, 0, 1, 16'h0000);
    fetch("err_20000", 32'h20000, 48'h0, 1'b1, 0, 1, 16'h0000);
    fetch("hit_after_err", 32'h1FFFA, 48'h010203040506, 1'b0, 0, 1, 16'h0000);

    // Flush two cycles into an odd miss.
    @(negedge clk);
    chk("fl.ready", 64'(fetch_ready), 64'd1);
    fetch_req  = 1'b1;
    fetch_addr = 32'h7;
    @(posedge clk);
    #1 fetch_req = 1'b0;
    @(negedge clk);
    chk("fl.rd1", 64'(mem_rd), 64'd1);
    @(posedge clk);
    #1 fetch_flush = 1'b1;
    @(negedge clk);
    chk("fl.rd2", 64'(mem_rd), 64'd1);
    @(posedge clk);
    #1 fetch_flush = 1'b0;
    nv = 0;
    for (int c = 3; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("fl.rd%0d", c), 64'(mem_rd), 64'd0);
      if (insn_valid) nv++;
    end
    chk("fl.no_valid", 64'(nv), 64'd0);
    chk("fl.ready_after", 64'(fetch_ready), 64'd1);
    fetch("fl.buf_inval", 32'h1FFFA, 48'h010203040506, 1'b0, 3, 5, 16'hFFFD);
    fetch("fl.refetch", 32'h7, 48'h112233445566, 1'b0, 4, 6, 16'h0003);

    // Reset two cycles into an even miss.
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    @(posedge clk);
    #1 fetch_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mr.ready", 64'(fetch_ready), 64'd0);
    chk("mr.valid", 64'(insn_valid), 64'd0);
    chk("mr.insn", 64'(insn), 64'd0);
    chk("mr.err", 64'(insn_err), 64'd0);
    chk("mr.rd", 64'(mem_rd), 64'd0);
    chk("mr.addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (insn_valid) nv++;
    end
    chk("mr.no_valid", 64'(nv), 64'd0);
    chk("mr.ready_after", 64'(fetch_ready), 64'd1);
    fetch("mr.buf_inval", 32'h7, 48'h112233445566, 1'b0, 4, 6, 16'h0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
